// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmitter.
// The parity state is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Brings the asynchronous baud square wave into the clk domain and turns its rising
// edge into a one-clk tick, registered so that it arrives 3 clks after the baud edge.
module uart_baud_tick (
  input  logic clk,
  input  logic rst,
  input  logic baud,
  output logic tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= baud;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_sync2 & ~r_prev;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_transmitter.sv
// Single-byte UART serializer: start, DATA_BITS data bits LSB-first, optional parity, stop.
// Defining UART_TX_PARITY_EN inserts a parity cell (even, or odd when PARITY_ODD=1).
//
// state  | meaning
// IDLE   | line at mark, waiting for tran_start
// ARM    | request accepted, waiting for a baud edge to align the start bit
// START  | start bit on the line
// DATA   | data bits, shift register bit 0 on the line
// PARITY | parity bit on the line (UART_TX_PARITY_EN only)
// STOP   | stop bit on the line
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] trans_data,
  input  logic       tran_start,
  input  logic       baud,
  output logic       txd,
  output logic       tx_busy
);

  state_t     r_state;
  logic [7:0] r_shift;
  logic [3:0] r_cnt;
  logic       r_txd;
  logic       r_busy;
  logic       w_tick;

`ifdef UART_TX_PARITY_EN
  logic       r_parity;
`else
  logic       w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  uart_baud_tick u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .baud (baud),
    .tick (w_tick)
  );

  // txd is loaded on each transition with the value of the state being entered,
  // so the line changes on the same clk as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shift  <= 8'd0;
      r_cnt    <= 4'd0;
      r_txd    <= TXD_IDLE;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= TXD_IDLE;
          if (tran_start) begin
            r_shift  <= trans_data;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b1;
            r_state  <= ARM;
`ifdef UART_TX_PARITY_EN
            r_parity <= PARITY_ODD;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        ARM: begin
          if (w_tick) begin
            r_state <= START;
            r_txd   <= START_BIT;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift  <= r_shift >> 1;
            r_cnt    <= r_cnt + 4'd1;
`ifdef UART_TX_PARITY_EN
            r_parity <= r_parity ^ r_shift[0];
`endif
            if (r_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_parity ^ r_shift[0];
`else
              r_state <= STOP;
              r_txd   <= TXD_IDLE;
`endif
            end else begin
              r_txd <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_txd   <= TXD_IDLE;
          end
        end
`endif
        STOP: begin
          r_txd <= TXD_IDLE;
          // tx_busy stays high here; IDLE clears it one clk later unless a new request is taken
          if (w_tick) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= TXD_IDLE;
        end
      endcase
    end
  end

  assign txd     = r_txd;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: reset, frames, ignored requests, mid-frame reset.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int CELLS = 11;
`else
  localparam int CELLS = 10;
`endif
  localparam int BAUD_CLKS  = 32;
  localparam bit PARITY_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] trans_data = 8'd0;
  logic       tran_start = 1'b0;
  logic       baud = 1'b0;
  logic       txd;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;

  uart_transmitter #(.DATA_BITS(8), .PARITY_ODD(PARITY_ODD)) dut (
    .clk        (clk),
    .rst        (rst),
    .trans_data (trans_data),
    .tran_start (tran_start),
    .baud       (baud),
    .txd        (txd),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (BAUD_CLKS / 2) @(negedge clk);
      baud = ~baud;
    end
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] exp_frame(input logic [7:0] d);
    logic [CELLS-1:0] f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = (^d) ^ PARITY_ODD;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Sends one byte and samples every cell at its middle, counting busy clks from the start bit.
  task automatic run_frame(input logic [7:0] d, input string tag, input bit inject);
    logic [CELLS-1:0] obs;
    int               busy_cnt;
    bit               found;
    @(negedge clk);
    check(tag, "busy_before", 32'(tx_busy), 32'd0);
    tran_start = 1'b1;
    trans_data = d;
    @(negedge clk);
    tran_start = 1'b0;
    trans_data = ~d;
    check(tag, "busy_after_accept", 32'(tx_busy), 32'd1);
    wait_start(found);
    check(tag, "start_seen", 32'(found), 32'd1);
    if (!found) return;
    obs      = '0;
    busy_cnt = 0;
    for (int i = 0; i < CELLS * BAUD_CLKS + 8; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_busy === 1'b1) busy_cnt++;
      if (i % BAUD_CLKS == BAUD_CLKS / 2) obs[i / BAUD_CLKS] = txd;
      if (inject && i == 100) begin
        tran_start = 1'b1;
        trans_data = 8'hFF;
      end
      if (inject && i == 101) tran_start = 1'b0;
    end
    check(tag, "frame_bits", 32'(obs), 32'(exp_frame(d)));
    check(tag, "busy_clks", 32'(busy_cnt), 32'(CELLS * BAUD_CLKS + 1));
    check(tag, "txd_after", 32'(txd), 32'd1);
    check(tag, "busy_after", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    bit found;
    int errs;

    #2 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tran_start = 1'($urandom);
      trans_data = 8'($urandom);
      @(negedge clk);
      check("reset", "txd", 32'(txd), 32'd1);
      check("reset", "busy", 32'(tx_busy), 32'd0);
    end
    tran_start = 1'b0;
    rst = 1'b1;
    errs = 0;
    for (int k = 0; k < 5 * BAUD_CLKS; k++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    check("idle", "bad_clks", 32'(errs), 32'd0);

    run_frame(8'hA5, "a5", 1'b0);
    run_frame(8'h3C, "3c", 1'b0);
    run_frame(8'h3C, "3c_ignore_ff", 1'b1);

    errs = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    check("no_extra_frame", "bad_clks", 32'(errs), 32'd0);

    @(negedge clk);
    tran_start = 1'b1;
    trans_data = 8'hA5;
    @(negedge clk);
    tran_start = 1'b0;
    wait_start(found);
    check("midreset", "start_seen", 32'(found), 32'd1);
    repeat (BAUD_CLKS / 2 + 5 * BAUD_CLKS) @(negedge clk);
    check("midreset", "data_bit4", 32'(txd), 32'd0);
    check("midreset", "busy_in_frame", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset", "txd_immediate", 32'(txd), 32'd1);
    check("midreset", "busy_immediate", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_frame(8'h5A, "5a_after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART serializer for a single byte. Sends one asynchronous frame: start bit, DATA_BITS data bits LSB-first, optional parity bit, stop bit.
- Bit timing comes from an externally generated `baud` square wave. One bit cell equals one full baud period, rising edge to rising edge.
- Sits between a host/register interface that issues `tran_start` and the chip's serial TX pad.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..8. `trans_data` is always 8 bits wide; only bits [DATA_BITS-1:0] are sent.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined; 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- trans_data  in  8  byte to send; sampled only on the accepting cycle.
- tran_start  in  1  start request; level-sampled each clk.
- baud  in  1  bit-rate square wave, asynchronous to clk; period must be at least 4 clk periods.
- txd  out  1  serial output; idle/mark = 1.
- tx_busy  out  1  high from the cycle after acceptance until the frame completes.

Behaviour:
- Reset (rst=0, asynchronous): txd=1, tx_busy=0, state=IDLE, shift register and bit counter cleared, baud synchronizer cleared.
- Baud tick: `baud` passes through a 2-flop synchronizer, then a rising-edge detector. The result is a one-clk pulse `tick`, 3 clks after the baud rising edge.
- States: IDLE, ARM, START, DATA, [PARITY], STOP.
- IDLE: txd=1, tx_busy=0.
  - If tran_start=1: latch trans_data into the shift register, clear the bit counter, go to ARM.
  - From the next clk, tx_busy=1.
  - A tick in the same cycle is ignored.
- ARM: txd=1. On tick go to START. Purpose: the start bit begins on a baud edge.
- START: txd=0. On tick go to DATA.
- DATA: txd = shift register bit 0.
  - On tick: shift right and increment the counter.
  - After DATA_BITS ticks go to PARITY if enabled, else STOP.
- PARITY: txd = computed parity. On tick go to STOP.
- STOP: txd=1. On tick go to IDLE; tx_busy falls on the following clk.
- Frame length: exactly (2 + DATA_BITS [+1]) baud periods after ARM.
- txd and tx_busy are registered outputs; no glitches.
- tran_start while tx_busy=1 is ignored and not queued. trans_data changes during a frame have no effect.
- tran_start held high continuously: a new frame is accepted on the first IDLE cycle after STOP. This gives back-to-back frames separated by the ARM wait.
- Tick coinciding with the STOP-to-IDLE transition plus tran_start: the request is accepted one clk later, in IDLE.
- Reset mid-frame: the frame is aborted, txd returns to 1 immediately, no partial stop bit.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after the data bits. Its value is the XOR of the sent data bits; the result is inverted when PARITY_ODD=1. Frame is 11 bit cells for DATA_BITS=8.
- Undefined: no parity state or logic, 8N1 frame of 10 bit cells.

Decomposition:
- Package uart_pkg: state enum typedef (IDLE, ARM, START, DATA, PARITY, STOP), localparam TXD_IDLE=1'b1, localparam START_BIT=1'b0.
- One sub-module: uart_baud_tick, containing the 2-flop synchronizer and rising-edge detector, outputting `tick`.
- The top contains the FSM, shift register, counter and parity logic.

Test Plan:
- Reset: hold rst=0 with random inputs -> txd=1, tx_busy=0. Release; with no tran_start, txd stays 1 across 5 baud periods.
- Send 8'hA5, baud period 32 clks, one-cycle tran_start pulse -> tx_busy=1 next clk. Line after ARM is 0 | 1,0,1,0,0,1,0,1 | 1, each cell 32 clks. tx_busy drops 1 clk after the stop cell ends.
- Send 8'h3C after the first frame completes -> 0 | 0,0,1,1,1,1,0,0 | 1; total busy time 10–11 baud periods.
- Pulse tran_start with 8'hFF mid-frame of 8'h3C -> ignored; waveform identical to the plain 3C frame; no extra frame afterwards.
- Assert rst=0 during data bit 4 of 8'hA5 -> txd=1 and tx_busy=0 immediately. A new 8'h5A request after release sends a clean full frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0, send 8'hA5 -> parity bit 0 before stop. With PARITY_ODD=1 -> 1. Frame is 11 cells.
